// File: rtl/ir_tx_pkg.sv
// Shared types and defaults for the IR transmit encoder.
package ir_tx_pkg;

  typedef enum logic [1:0] {
    MODE_BIPHASE = 2'd0,
    MODE_PDIST   = 2'd1,
    MODE_PLEN    = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEG_A = 2'd1,
    ST_SEG_B = 2'd2
  } state_e;

  localparam int DEF_CARR_PERIOD = 26;
  localparam int DEF_CARR_HIGH   = 9;
  localparam int DEF_T0          = 21;
  localparam int DEF_T1          = 21;
  localparam int DEF_T2          = 64;

  // Mode 3 is undefined and falls through to bi-phase.
  function automatic logic seg_is_carrier(logic [1:0] mode, logic seg_b, logic b);
    case (mode)
      MODE_PDIST, MODE_PLEN: return !seg_b;
      default:               return seg_b ? b : !b;
    endcase
  endfunction

endpackage

// File: rtl/ir_tx_encoder_if.sv
// Frame request handshake between a frame source and the IR encoder.
interface ir_tx_encoder_if #(parameter int DATA_W = 32);
  logic              i_tx_valid;
  logic [DATA_W-1:0] i_tx_data;
  logic              o_tx_ready;

  modport master (output i_tx_valid, output i_tx_data, input  o_tx_ready);
  modport slave  (input  i_tx_valid, input  i_tx_data, output o_tx_ready);
endinterface

// File: rtl/ir_carrier_gen.sv
// Free-running carrier period counter; reports the level for the next cycle so the
// encoder can register its output without an extra cycle of latency.
module ir_carrier_gen #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             restart,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] high,
  output logic             wrap,
  output logic             carr_nxt
);

  logic [CNT_W-1:0] cnt, cnt_nxt, last;

  always_comb begin
    last = (period < CNT_W'(2)) ? CNT_W'(1) : period - CNT_W'(1);
    wrap = !restart && (cnt >= last);
    if (restart || cnt >= last) cnt_nxt = '0;
    else                        cnt_nxt = cnt + CNT_W'(1);
    // high >= period saturates to 1, high == 0 to 0, without special cases
    carr_nxt = (cnt_nxt < high);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else     cnt <= cnt_nxt;
  end

endmodule

// File: rtl/ir_tx_encoder.sv
// IR transmit encoder: bi-phase, pulse-distance and pulse-length coding of a
// captured frame onto a modulated carrier.
//   state    | meaning
//   ST_IDLE  | ready for a frame, output silent
//   ST_SEG_A | first segment of the current bit
//   ST_SEG_B | second segment of the current bit
module ir_tx_encoder
  import ir_tx_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       i_mode,
  input  logic [CNT_W-1:0] i_carr_period,
  input  logic [CNT_W-1:0] i_carr_high,
  input  logic [CNT_W-1:0] i_t0,
  input  logic [CNT_W-1:0] i_t1,
  input  logic [CNT_W-1:0] i_t2,
  input  logic [5:0]       i_nbits,
  input  logic             i_abort,
  ir_tx_encoder_if.slave   tx,
  output logic             o_ir_dout,
  output logic             o_busy,
  output logic             o_done
);

  localparam int BW = $clog2(DATA_W + 1);

  state_e            state, state_nxt;
  logic [1:0]        mode_q, mode_nxt;
  logic [DATA_W-1:0] data_q, data_nxt;
  logic [BW-1:0]     bits_q, bits_nxt, nbits_eff;
  logic [CNT_W-1:0]  seg_q, seg_nxt;
  logic [CNT_W-1:0]  t0_q, t1_q, t2_q, per_q, high_q;
  logic              idle, accept, wrap, carr_nxt, done_nxt, dout_nxt;

  function automatic logic [CNT_W-1:0] seg_len(logic [1:0] mode, logic seg_b, logic b,
                                               logic [CNT_W-1:0] t0, logic [CNT_W-1:0] t1,
                                               logic [CNT_W-1:0] t2);
    logic [CNT_W-1:0] n;
    case (mode)
      MODE_PDIST: n = seg_b ? (b ? t2 : t1) : t0;
      MODE_PLEN:  n = seg_b ? t2 : (b ? t1 : t0);
      default:    n = t0;
    endcase
    return (n == '0) ? CNT_W'(1) : n;
  endfunction

  assign idle          = (state == ST_IDLE);
  assign accept        = idle && tx.i_tx_valid;
  assign tx.o_tx_ready = idle;
  assign o_busy        = !idle;

  always_comb begin
    if (int'(i_nbits) > DATA_W) nbits_eff = BW'(DATA_W);
    else                        nbits_eff = BW'(i_nbits);
  end

  // While idle the carrier follows the live inputs so the first output cycle is right.
  ir_carrier_gen #(.CNT_W(CNT_W)) u_carrier (
    .clk      (clk),
    .rst      (rst),
    .restart  (idle),
    .period   (idle ? i_carr_period : per_q),
    .high     (idle ? i_carr_high : high_q),
    .wrap     (wrap),
    .carr_nxt (carr_nxt)
  );

  always_comb begin
    state_nxt = state;
    mode_nxt  = mode_q;
    data_nxt  = data_q;
    bits_nxt  = bits_q;
    seg_nxt   = seg_q;
    done_nxt  = 1'b0;
    case (state)
      ST_IDLE: if (tx.i_tx_valid) begin
        mode_nxt = i_mode;
        data_nxt = tx.i_tx_data;
        bits_nxt = nbits_eff;
        if (nbits_eff == '0) done_nxt = 1'b1;
        else begin
          state_nxt = ST_SEG_A;
          seg_nxt   = seg_len(i_mode, 1'b0, tx.i_tx_data[0], i_t0, i_t1, i_t2);
        end
      end
      ST_SEG_A: if (wrap) begin
        if (seg_q > CNT_W'(1)) seg_nxt = seg_q - CNT_W'(1);
        else begin
          state_nxt = ST_SEG_B;
          seg_nxt   = seg_len(mode_q, 1'b1, data_q[0], t0_q, t1_q, t2_q);
        end
      end
      ST_SEG_B: if (wrap) begin
        if (seg_q > CNT_W'(1)) seg_nxt = seg_q - CNT_W'(1);
        else begin
          bits_nxt = bits_q - BW'(1);
          data_nxt = data_q >> 1;
          if (bits_q == BW'(1)) begin
            state_nxt = ST_IDLE;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = ST_SEG_A;
            seg_nxt   = seg_len(mode_q, 1'b0, data_nxt[0], t0_q, t1_q, t2_q);
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (i_abort && !idle) begin
      state_nxt = ST_IDLE;
      done_nxt  = 1'b0;
    end
    dout_nxt = (state_nxt != ST_IDLE) && carr_nxt &&
               seg_is_carrier(mode_nxt, state_nxt == ST_SEG_B, data_nxt[0]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      mode_q    <= '0;
      data_q    <= '0;
      bits_q    <= '0;
      seg_q     <= '0;
      t0_q      <= '0;
      t1_q      <= '0;
      t2_q      <= '0;
      per_q     <= '0;
      high_q    <= '0;
      o_ir_dout <= 1'b0;
      o_done    <= 1'b0;
    end else begin
      state     <= state_nxt;
      mode_q    <= mode_nxt;
      data_q    <= data_nxt;
      bits_q    <= bits_nxt;
      seg_q     <= seg_nxt;
      o_ir_dout <= dout_nxt;
      o_done    <= done_nxt;
      if (accept) begin
        t0_q   <= i_t0;
        t1_q   <= i_t1;
        t2_q   <= i_t2;
        per_q  <= i_carr_period;
        high_q <= i_carr_high;
      end
    end
  end

endmodule

// File: tb/tb_ir_tx_encoder.sv
// Scoreboard bench for ir_tx_encoder: a per-cycle model of each frame is queued at
// acceptance and compared against the DUT outputs one cycle at a time.
module tb_ir_tx_encoder;
  import ir_tx_pkg::*;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [1:0]       i_mode = '0;
  logic [CNT_W-1:0] i_carr_period = '0, i_carr_high = '0;
  logic [CNT_W-1:0] i_t0 = '0, i_t1 = '0, i_t2 = '0;
  logic [5:0]       i_nbits = '0;
  logic             i_abort = 1'b0;
  logic             o_ir_dout, o_busy, o_done;

  ir_tx_encoder_if #(.DATA_W(DATA_W)) tx ();

  ir_tx_encoder #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_mode        (i_mode),
    .i_carr_period (i_carr_period),
    .i_carr_high   (i_carr_high),
    .i_t0          (i_t0),
    .i_t1          (i_t1),
    .i_t2          (i_t2),
    .i_nbits       (i_nbits),
    .i_abort       (i_abort),
    .tx            (tx),
    .o_ir_dout     (o_ir_dout),
    .o_busy        (o_busy),
    .o_done        (o_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic dout;
    logic busy;
    logic done;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  bit   mon_on   = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("dout", o_ir_dout, e.dout);
      check("busy", o_busy, e.busy);
      check("done", o_done, e.done);
    end else if (mon_on) begin
      check("idle_dout", o_ir_dout, 0);
      check("idle_busy", o_busy, 0);
      check("idle_done", o_done, 0);
    end
  end

  task automatic model_seg(input logic car, input int len, input int pe, input int h);
    int n;
    n = (len == 0) ? 1 : len;
    for (int s = 0; s < n; s++)
      for (int k = 0; k < pe; k++)
        exp_q.push_back(exp_t'{car && (k < h), 1'b1, 1'b0});
  endtask

  task automatic model_frame(input int m, input int p, input int h, input int t0, input int t1,
                             input int t2, input int nb, input logic [DATA_W-1:0] d);
    int   pe, ne, la, lb;
    logic ca, cb, b;
    pe = (p < 2) ? 2 : p;
    ne = (nb > DATA_W) ? DATA_W : nb;
    for (int i = 0; i < ne; i++) begin
      b = d[i];
      case (m)
        1:       begin ca = 1'b1; la = t0;           cb = 1'b0; lb = b ? t2 : t1; end
        2:       begin ca = 1'b1; la = b ? t1 : t0;  cb = 1'b0; lb = t2;          end
        default: begin ca = !b;   la = t0;           cb = b;    lb = t0;          end
      endcase
      model_seg(ca, la, pe, h);
      model_seg(cb, lb, pe, h);
    end
    exp_q.push_back(exp_t'{1'b0, 1'b0, 1'b1});
  endtask

  // Called just after a falling edge; returns at the falling edge after acceptance.
  task automatic send(input int m, input int p, input int h, input int t0, input int t1,
                      input int t2, input int nb, input logic [DATA_W-1:0] d, input bit b2b);
    int w = 0;
    while (!tx.o_tx_ready && w < 2000) begin
      @(negedge clk);
      w++;
    end
    check("ready_wait", tx.o_tx_ready, 1);
    if (b2b) check("b2b_done", o_done, 1);
    i_mode        = 2'(m);
    i_carr_period = CNT_W'(p);
    i_carr_high   = CNT_W'(h);
    i_t0          = CNT_W'(t0);
    i_t1          = CNT_W'(t1);
    i_t2          = CNT_W'(t2);
    i_nbits       = 6'(nb);
    tx.i_tx_data  = d;
    tx.i_tx_valid = 1'b1;
    model_frame(m, p, h, t0, t1, t2, nb, d);
    @(negedge clk);
    tx.i_tx_valid = 1'b0;
    i_mode        = 2'($urandom);
    i_carr_period = CNT_W'($urandom_range(0, 9));
    i_carr_high   = CNT_W'($urandom_range(0, 9));
    i_t0          = CNT_W'($urandom_range(0, 5));
    i_t1          = CNT_W'($urandom_range(0, 5));
    i_t2          = CNT_W'($urandom_range(0, 5));
    i_nbits       = 6'($urandom);
    tx.i_tx_data  = DATA_W'($urandom);
  endtask

  task automatic wait_drain();
    int w = 0;
    while (exp_q.size() > 0 && w < 5000) begin
      @(negedge clk);
      w++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  initial begin
    tx.i_tx_valid = 1'b0;
    tx.i_tx_data  = '0;
    repeat (3) @(negedge clk);
    check("rst_dout", o_ir_dout, 0);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    rst = 1'b0;
    mon_on = 1'b1;
    @(negedge clk);
    check("rst_ready", tx.o_tx_ready, 1);

    send(0, 4, 1, 2, 0, 0, 2, 32'b01, 0);
    wait_drain();
    send(1, 4, 2, 1, 1, 3, 2, 32'b10, 0);
    wait_drain();
    send(2, 2, 1, 1, 3, 2, 1, 32'b1, 0);
    wait_drain();
    send(0, 4, 1, 2, 0, 0, 0, 32'hFF, 0);
    wait_drain();
    send(0, 0, 5, 1, 0, 0, 1, 32'b0, 0);
    wait_drain();

    send(1, 3, 1, 1, 2, 1, 3, 32'b101, 0);
    send(2, 2, 1, 2, 1, 1, 2, 32'b01, 1);
    wait_drain();

    send(0, 4, 2, 2, 0, 0, 32, 32'hA5C3_0F96, 0);
    repeat (4) @(negedge clk);
    i_abort = 1'b1;
    exp_q.delete();
    @(negedge clk);
    i_abort = 1'b0;
    check("abort_ready", tx.o_tx_ready, 1);
    check("abort_dout", o_ir_dout, 0);
    repeat (5) @(negedge clk);

    i_abort = 1'b1;
    send(1, 3, 2, 1, 1, 2, 3, 32'b110, 0);
    i_abort = 1'b0;
    wait_drain();

    send(0, 3, 2, 2, 0, 0, 32, 32'h1234_5678, 0);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("arst_dout", o_ir_dout, 0);
    check("arst_busy", o_busy, 0);
    check("arst_done", o_done, 0);
    check("arst_ready", tx.o_tx_ready, 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);

    for (int r = 0; r < 6; r++) begin
      send(int'($urandom_range(0, 3)), int'($urandom_range(0, 5)), int'($urandom_range(0, 6)),
           int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
           int'($urandom_range(0, 40)), DATA_W'($urandom), 0);
      wait_drain();
    end

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
